// File: rtl/imem_prog_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Holds the loader state encoding and the frame geometry.
package imem_prog_loader_pkg;

    localparam int DATA_W         = 32;
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_LO = 3'd1,
        S_CNT_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CSUM   = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    // States in which the loader takes bytes from the host link.
    function automatic logic takes_bytes(state_t s);
        return (s == S_CNT_LO) || (s == S_CNT_HI) ||
               (s == S_DATA)   || (s == S_CSUM);
    endfunction

    // States that make up an active load.
    function automatic logic is_busy(state_t s);
        return takes_bytes(s) || (s == S_WRITE);
    endfunction

endpackage

// File: rtl/imem_prog_loader_word_assembler.sv
// Assembles little-endian bytes into 32-bit words for the program loader.
// Ports: clk, rst_n, clr, acc, byte_in in; word (next word value), word_full out.
module loader_word_assembler
    import imem_prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              acc,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic              word_full
);

    logic [DATA_W-1:0]     word_q;
    logic [DATA_W-1:0]     word_d;
    logic [BYTE_IDX_W-1:0] idx_q;
    logic [BYTE_IDX_W-1:0] idx_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clr) begin
            word_d = '0;
            idx_d  = '0;
        end else if (acc) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_in;
            idx_d = idx_q + BYTE_IDX_W'(1);
        end
    end

    // word exposes the merged value so the 4th byte is visible in the
    // same cycle that word_full fires.
    assign word      = word_d;
    assign word_full = acc && !clr &&
                       (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/imem_prog_loader.sv
// Loads a checksummed byte-stream image into instruction memory and holds
// the core in reset until the image is verified.
// Ports: clk, rst_n, start, rx_data/rx_valid in; rx_ready, imem_we/addr/wdata,
// core_rst_n, busy, done, err, words_loaded out.
module imem_prog_loader
    import imem_prog_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [CNT_W:0] MAX_N = (CNT_W + 1)'(2 ** ADDR_W);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [ADDR_W:0]   words_q;
    logic [ADDR_W:0]   words_d;
    logic [7:0]        xor_q;
    logic [7:0]        xor_d;
    logic              we_q;
    logic              we_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata_d;

    logic              accept;
    logic              asm_clr;
    logic              asm_acc;
    logic [DATA_W-1:0] asm_word;
    logic              asm_full;
    logic [CNT_W-1:0]  n_hdr;
    logic [ADDR_W:0]   words_nxt;

    loader_word_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (asm_clr),
        .acc       (asm_acc),
        .byte_in   (rx_data),
        .word      (asm_word),
        .word_full (asm_full)
    );

    always_comb begin
        rx_ready   = takes_bytes(state_q);
        busy       = is_busy(state_q);
        done       = (state_q == S_DONE);
        err        = (state_q == S_ERR);
        core_rst_n = (state_q == S_DONE);
    end

    assign accept       = rx_valid && rx_ready;
    assign asm_acc      = accept && (state_q == S_DATA);
    assign n_hdr        = CNT_W'({rx_data, cnt_q[7:0]});
    assign words_nxt    = words_q + (ADDR_W + 1)'(1);
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = words_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        xor_d   = xor_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        asm_clr = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_CNT_LO;
                    words_d = '0;
                    xor_d   = '0;
                    asm_clr = 1'b1;
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    cnt_d   = CNT_W'(rx_data);
                    xor_d   = xor_q ^ rx_data;
                    state_d = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (accept) begin
                    cnt_d = n_hdr;
                    xor_d = xor_q ^ rx_data;
                    if ({1'b0, n_hdr} > MAX_N) begin
                        state_d = S_ERR;
                    end else if (n_hdr == '0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    xor_d = xor_q ^ rx_data;
                    // Latch the write on the 4th byte so the strobe,
                    // address and data are all registered in WRITE.
                    if (asm_full) begin
                        we_d    = 1'b1;
                        addr_d  = words_q[ADDR_W-1:0];
                        wdata_d = asm_word;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                words_d = words_nxt;
                if (CNT_W'(words_nxt) == cnt_q) begin
                    state_d = S_CSUM;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (rx_data == xor_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            words_q <= '0;
            xor_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
            xor_q   <= xor_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_imem_prog_loader.sv
// Self-checking bench for imem_prog_loader: vector table, corner sequences
// and random frames checked against a frame-level reference model.
module tb_imem_prog_loader;

    localparam int ADDR_W = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst_n;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    imem_prog_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst_n   (core_rst_n),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0] wa[$];
    logic [31:0]       wd[$];
    logic [7:0]        frame[$];
    logic [31:0]       exp_wd[$];
    bit                m_done;
    bit                m_err;
    int                m_n;

    // Write log; a strobe wider than one cycle shows up as extra entries.
    always @(negedge clk) begin
        if (imem_we) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
            total++;
            if (rx_ready !== 1'b0) begin
                bad++;
                $display("FAIL rx_ready_in_write act=%0b exp=0", rx_ready);
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Frame-level reference: parse header, collect words, verify XOR.
    task automatic model();
        int n;
        logic [7:0] x;
        m_wd_clear();
        n = int'(frame[0]) | (int'(frame[1]) << 8);
        if (n > (1 << ADDR_W)) begin
            m_done = 1'b0;
            m_err  = 1'b1;
            m_n    = 0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            exp_wd.push_back({frame[2+4*i+3], frame[2+4*i+2],
                              frame[2+4*i+1], frame[2+4*i]});
        end
        x = 8'h00;
        for (int i = 0; i < frame.size() - 1; i++) x ^= frame[i];
        m_done = (frame[frame.size()-1] == x);
        m_err  = !m_done;
        m_n    = n;
    endtask

    task automatic m_wd_clear();
        exp_wd.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (rx_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout act=stalled exp=byte_%0h", b);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_range(input int from, input int to, input int gap_max);
        for (int i = from; i < to; i++) begin
            send_byte(frame[i], gap_max > 0 ? int'($urandom_range(gap_max, 0)) : 0);
        end
    endtask

    task automatic check_result(input string tag, input bit edone,
                                input bit eerr, input int ewords);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, "_nwr"}, 64'(wa.size()), 64'(exp_wd.size()));
        for (int i = 0; i < wa.size() && i < exp_wd.size(); i++) begin
            chk({tag, "_addr"}, 64'(wa[i]), 64'(i));
            chk({tag, "_wdata"}, 64'(wd[i]), 64'(exp_wd[i]));
        end
        chk({tag, "_done"}, 64'(done), 64'(edone));
        chk({tag, "_err"}, 64'(err), 64'(eerr));
        chk({tag, "_core_rst_n"}, 64'(core_rst_n), 64'(edone));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_rx_ready"}, 64'(rx_ready), 64'(0));
        chk({tag, "_words"}, 64'(words_loaded), 64'(ewords));
    endtask

    task automatic load_normal();
        frame.delete();
        frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                  8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
        exp_wd.delete();
        exp_wd.push_back(32'h00500093);
        exp_wd.push_back(32'h00A00113);
    endtask

    typedef struct {
        logic [7:0]  b[12];
        int          len;
        int          gap;
        bit          edone;
        bit          eerr;
        int          ewords;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t tv[5];

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        tv[0] = '{b: '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13,
                       8'h01, 8'hA0, 8'h00, 8'h73, 8'h00},
                  len: 11, gap: 0, edone: 1, eerr: 0, ewords: 2,
                  w0: 32'h00500093, w1: 32'h00A00113};
        tv[1] = '{b: '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13,
                       8'h01, 8'hA0, 8'h00, 8'h74, 8'h00},
                  len: 11, gap: 0, edone: 0, eerr: 1, ewords: 2,
                  w0: 32'h00500093, w1: 32'h00A00113};
        tv[2] = '{b: '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                       8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  len: 2, gap: 0, edone: 0, eerr: 1, ewords: 0,
                  w0: 32'h0, w1: 32'h0};
        tv[3] = '{b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                       8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  len: 3, gap: 0, edone: 1, eerr: 0, ewords: 0,
                  w0: 32'h0, w1: 32'h0};
        tv[4] = '{b: '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13,
                       8'h01, 8'hA0, 8'h00, 8'h73, 8'h00},
                  len: 11, gap: 3, edone: 1, eerr: 0, ewords: 2,
                  w0: 32'h00500093, w1: 32'h00A00113};

        repeat (2) @(negedge clk);
        chk("rst_core_rst_n", 64'(core_rst_n), 64'(0));
        chk("rst_rx_ready", 64'(rx_ready), 64'(0));
        chk("rst_imem_we", 64'(imem_we), 64'(0));
        chk("rst_busy_done_err", 64'({busy, done, err}), 64'(0));
        chk("rst_words", 64'(words_loaded), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            frame.delete();
            for (int i = 0; i < tv[v].len; i++) frame.push_back(tv[v].b[i]);
            exp_wd.delete();
            if (tv[v].ewords > 0) exp_wd.push_back(tv[v].w0);
            if (tv[v].ewords > 1) exp_wd.push_back(tv[v].w1);
            wa.delete();
            wd.delete();
            pulse_start();
            send_range(0, frame.size(), tv[v].gap);
            check_result($sformatf("vec%0d", v), tv[v].edone, tv[v].eerr,
                         tv[v].ewords);
        end

        // Oversize header: error right after the count is taken.
        wa.delete();
        wd.delete();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        chk("ovs_err_next", 64'(err), 64'(1));
        chk("ovs_rx_ready", 64'(rx_ready), 64'(0));
        chk("ovs_busy", 64'(busy), 64'(0));
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("ovs_nwr", 64'(wa.size()), 64'(0));

        // Empty image, then a restart from DONE.
        frame.delete();
        frame = '{8'h00, 8'h00, 8'h00};
        exp_wd.delete();
        pulse_start();
        send_range(0, 3, 0);
        check_result("empty", 1'b1, 1'b0, 0);
        pulse_start();
        chk("restart_core_rst_n", 64'(core_rst_n), 64'(0));
        chk("restart_busy", 64'(busy), 64'(1));
        chk("restart_done", 64'(done), 64'(0));
        wa.delete();
        wd.delete();
        load_normal();
        send_range(0, frame.size(), 0);
        check_result("restart", 1'b1, 1'b0, 2);

        // start while busy must be ignored.
        wa.delete();
        wd.delete();
        load_normal();
        pulse_start();
        send_range(0, 3, 0);
        start = 1'b1;
        send_range(3, 5, 0);
        start = 1'b0;
        send_range(5, frame.size(), 0);
        check_result("start_busy", 1'b1, 1'b0, 2);

        // Reset after 5 data bytes: one word already written.
        wa.delete();
        wd.delete();
        load_normal();
        pulse_start();
        send_range(0, 7, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", 64'({imem_we, core_rst_n, rx_ready, busy,
                                 done, err}), 64'(0));
        chk("mid_rst_addr", 64'(imem_addr), 64'(0));
        chk("mid_rst_wdata", 64'(imem_wdata), 64'(0));
        chk("mid_rst_words", 64'(words_loaded), 64'(0));
        rx_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_nwr", 64'(wa.size()), 64'(1));
        rst_n = 1'b1;
        @(negedge clk);
        wa.delete();
        wd.delete();
        load_normal();
        pulse_start();
        send_range(0, frame.size(), 0);
        check_result("post_rst", 1'b1, 1'b0, 2);

        // Random frames against the reference model.
        for (int r = 0; r < 7; r++) begin
            int n;
            logic [7:0] x;
            logic [7:0] bv;
            if (r == 0) n = int'($urandom_range(1000, 257));
            else if (r == 6) n = 1 << ADDR_W;
            else n = int'($urandom_range(8, 1));
            frame.delete();
            bv = n[7:0];
            frame.push_back(bv);
            bv = n[15:8];
            frame.push_back(bv);
            if (n <= (1 << ADDR_W)) begin
                for (int i = 0; i < 4 * n; i++) begin
                    bv = 8'($urandom);
                    frame.push_back(bv);
                end
                x = 8'h00;
                foreach (frame[i]) x ^= frame[i];
                if ($urandom_range(1, 0) == 1 && r != 6) begin
                    x ^= 8'($urandom_range(255, 1));
                end
                frame.push_back(x);
            end
            model();
            wa.delete();
            wd.delete();
            pulse_start();
            send_range(0, frame.size(), r == 6 ? 1 : 3);
            check_result($sformatf("rand%0d", r), m_done, m_err, m_n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_prog_loader.md
Name: imem_prog_loader

Overview:
- Hardware counterpart to the bench's backdoor memory load: receives a byte stream (host/UART side), assembles little-endian 32-bit words and writes them into instruction memory through its write port.
- Holds the RISC-V core in reset until the image is loaded and its checksum verified, then releases it.
- Sits between the host byte link and the instruction memory / core reset inside the top-level module.

Parameters:
- ADDR_W, 8, instruction memory word-address width; depth = 2**ADDR_W words.
- CNT_W, 16, width of the word-count header field.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a load; honoured only in IDLE, DONE or ERR
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte; transfer occurs when rx_valid && rx_ready at the clock edge
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address of the write
- imem_wdata  out  32  word written
- core_rst_n  out  1  active-low reset to the core
- busy  out  1  load in progress
- done  out  1  image loaded and checksum OK
- err  out  1  load failed; sticky until the next start
- words_loaded  out  ADDR_W+1  count of words written in the current load

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0, including core_rst_n=0, rx_ready=0 and words_loaded=0.
  - Partially assembled data is discarded.
- Frame format:
  - CNT_LO, CNT_HI: N, little-endian.
  - N×4 data bytes, each word least-significant byte first.
  - One checksum byte = XOR of every preceding frame byte, including the header.
- States: IDLE, CNT_LO, CNT_HI, DATA, WRITE, CSUM, DONE, ERR.
- Transitions:
  - IDLE/DONE/ERR + start: go to CNT_LO. Clear words_loaded, the running XOR, done and err; drive core_rst_n=0.
  - CNT_LO: on accept, go to CNT_HI.
  - CNT_HI: on accept:
    - if N > 2**ADDR_W, go to ERR;
    - else if N==0, go to CSUM;
    - else go to DATA.
  - DATA: on each accept, shift the byte into the word at lane byte_idx (2-bit counter). On the 4th accept, go to WRITE.
  - WRITE: lasts exactly one cycle.
    - imem_we=1, imem_addr=words_loaded[ADDR_W-1:0], imem_wdata=assembled word.
    - Next cycle words_loaded increments.
    - If the new count equals N, go to CSUM; else go to DATA.
  - CSUM: on accept, if byte == running XOR go to DONE, else go to ERR.
- rx_ready:
  - 1 only in CNT_LO, CNT_HI, DATA and CSUM.
  - 0 in IDLE, WRITE, DONE and ERR.
  - This gives a one-cycle bubble per word.
- State outputs:
  - busy=1 in CNT_LO through CSUM.
  - DONE: done=1, core_rst_n=1.
  - ERR: err=1, core_rst_n=0.
  - core_rst_n=1 only in DONE.
- Registered outputs: imem_addr and imem_wdata hold their last values outside WRITE; imem_we is 0 outside WRITE.
- start while busy: ignored.
- rx_valid gaps: no effect on the byte count; the loader simply waits.
- Reset mid-load: immediate return to IDLE. Words already written stay in imem; no further writes occur.
- Largest image: N == 2**ADDR_W is legal; the last write is at address 2**ADDR_W-1.

Decomposition:
- Shared package/include holds:
  - the state encoding localparams;
  - DATA_W=32;
  - HDR_BYTES=2 and BYTES_PER_WORD=4.
- One natural sub-module, loader_word_assembler:
  - 4-byte shift register plus byte_idx counter;
  - inputs: byte, accept strobe and clear;
  - outputs: the 32-bit word and word_full.
- The FSM, address counter and checksum stay in imem_prog_loader.

Test Plan:
- Normal load, ADDR_W=8:
  - Stimulus: start, then bytes 02 00 93 00 50 00 13 01 A0 00 73.
  - Expect imem writes addr0=0x00500093 and addr1=0x00A00113, each with imem_we high for exactly 1 cycle.
  - Then done=1, core_rst_n=1, words_loaded=2.
- Bad checksum:
  - Stimulus: same frame with last byte 74.
  - Expect both writes to occur, then err=1, done=0, core_rst_n stays 0.
- Oversize header:
  - Stimulus: bytes 01 01 (N=257).
  - Expect err=1 in the cycle after CNT_HI is accepted, no imem_we, and rx_ready=0 afterwards.
- Empty image:
  - Stimulus: bytes 00 00 00.
  - Expect no writes and done=1.
  - Then a start in DONE drops core_rst_n to 0 and busy to 1.
- Backpressure and gaps:
  - Stimulus: normal frame with rx_valid deasserted for 3 random cycles between bytes; rx_valid held high during WRITE.
  - Expect rx_ready=0 during WRITE, no byte lost or duplicated, and a result identical to the normal-load case.
- Reset mid-load:
  - Stimulus: assert rst_n=0 after 5 data bytes (one word written).
  - Expect immediate IDLE with all outputs 0.
  - Then a fresh start plus the normal frame gives done=1.
